// File: rtl/fifo_burst_writer.sv
// fifo_burst_writer
//   Read-side drain stage for the camera-to-SDRAM asynchronous FIFO. Waits
//   until the FIFO holds a full burst, issues one write command, then streams
//   exactly BURST_LEN words from the first-word-fall-through head into the
//   SDRAM controller. Addresses are frame-relative and wrap at the end of each
//   frame, so the frame buffer fills linearly from BASE_ADDR.
//
// Ports
//   clk         single clock (FIFO read clock)
//   rst         synchronous active-high reset
//   fifo_empty  FIFO empty flag
//   fifo_count  FIFO occupancy (may under-report, never over-reports)
//   fifo_data   FIFO head word (FWFT)
//   fifo_read   pop request, combinational
//   frame_start one-cycle pulse, restarts addressing at BASE_ADDR
//   cmd_valid   write command valid
//   cmd_ready   controller accepts command
//   cmd_addr    burst start address
//   wr_valid    write data valid
//   wr_ready    controller accepts data beat
//   wr_data     write data (FIFO head)
//   busy        high while not idle (registered)
//   frame_done  one-cycle pulse after the last burst of a frame
module fifo_burst_writer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned COUNT_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned BURST_LEN   = 8,
  parameter int unsigned FRAME_WORDS = 76800,
  parameter int unsigned BASE_ADDR   = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fifo_empty,
  input  logic [COUNT_WIDTH-1:0] fifo_count,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_read,
  input  logic                   frame_start,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [ADDR_WIDTH-1:0]  cmd_addr,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   busy,
  output logic                   frame_done
);

  localparam int unsigned BEAT_WIDTH = $clog2(BURST_LEN);

  localparam logic [ADDR_WIDTH-1:0]  BASE        = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]    STEP        = (ADDR_WIDTH+1)'(BURST_LEN);
  localparam logic [ADDR_WIDTH:0]    END_ADDR    = (ADDR_WIDTH+1)'(BASE_ADDR)
                                                 + (ADDR_WIDTH+1)'(FRAME_WORDS);
  localparam logic [COUNT_WIDTH-1:0] BURST_COUNT = COUNT_WIDTH'(BURST_LEN);
  localparam logic [BEAT_WIDTH-1:0]  LAST_BEAT   = BEAT_WIDTH'(BURST_LEN - 1);
  localparam logic [BEAT_WIDTH-1:0]  BEAT_ONE    = BEAT_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    pending_q, pending_d;
  logic [BEAT_WIDTH-1:0]   beat_q, beat_d;
  logic                    frame_done_q, frame_done_d;
  logic                    busy_q;

  logic                    wr_hs;
  logic [ADDR_WIDTH:0]     addr_sum;

  assign wr_hs    = (state_q == DATA) && !fifo_empty && wr_ready;
  // One extra bit so a frame ending exactly at 2^ADDR_WIDTH still compares.
  assign addr_sum = {1'b0, addr_q} + STEP;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= BASE;
      pending_q    <= 1'b0;
      beat_q       <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pending_q    <= pending_d;
      beat_q       <= beat_d;
      frame_done_q <= frame_done_d;
      busy_q       <= (state_d != IDLE);
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pending_d    = pending_q;
    beat_d       = beat_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start || pending_q) begin
          addr_d    = BASE;
          pending_d = 1'b0;
        end else if (fifo_count >= BURST_COUNT) begin
          state_d = CMD;
        end
      end

      CMD: begin
        if (frame_start) begin
          pending_d = 1'b1;
        end
        if (cmd_ready) begin
          beat_d  = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        // A restart requested mid-burst waits for the next idle cycle so the
        // in-flight burst lands at the address it was commanded with.
        if (frame_start) begin
          pending_d = 1'b1;
        end
        if (wr_hs) begin
          beat_d = beat_q + BEAT_ONE;
          if (beat_q == LAST_BEAT) begin
            state_d = IDLE;
            if (addr_sum == END_ADDR) begin
              addr_d       = BASE;
              frame_done_d = 1'b1;
            end else begin
              addr_d = addr_sum[ADDR_WIDTH-1:0];
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    cmd_valid  = (state_q == CMD);
    cmd_addr   = addr_q;
    // Gated by rst so no word is popped in the cycle a reset is applied.
    wr_valid   = (state_q == DATA) && !fifo_empty && !rst;
    fifo_read  = (state_q == DATA) && !fifo_empty && !rst && wr_ready;
    wr_data    = fifo_data;
    busy       = busy_q;
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_fifo_burst_writer.sv
// tb_fifo_burst_writer
//   Directed bench for fifo_burst_writer with BURST_LEN=8, FRAME_WORDS=32.
//   A bench-side FWFT FIFO supplies words; every pushed word is also queued as
//   expected write data, and every expected burst address is queued before the
//   burst. Handshakes observed on the DUT pop and compare those queues.
module tb_fifo_burst_writer;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 10;
  localparam int unsigned AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [DW-1:0] fifo_data;
  logic          fifo_read;
  logic          frame_start;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic          wr_valid;
  logic          wr_ready;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          frame_done;

  fifo_burst_writer #(
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW),
    .ADDR_WIDTH (AW),
    .BURST_LEN  (8),
    .FRAME_WORDS(32),
    .BASE_ADDR  (0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_count (fifo_count),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .frame_start(frame_start),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_data[$];
  int            exp_addr[$];
  logic          hide;
  logic          do_pop;
  logic          prev_rd;
  logic [DW-1:0] next_word;

  int checks;
  int errors;
  int cyc;
  int n_reads;
  int n_busy;
  int n_fd;
  int first_rd;
  int last_rd;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic void refresh();
    fifo_empty = hide || (fq.size() == 0);
    fifo_count = hide ? '0 : CW'(fq.size());
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
  endfunction

  task automatic push(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(next_word);
      exp_data.push_back(next_word);
      next_word = next_word + 16'd1;
    end
    refresh();
  endtask

  // One clock: observe at the falling edge, then update the FIFO model just
  // after the rising edge so the next head word appears the following cycle.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (!rst) begin
      check("rd_is_handshake", fifo_read, wr_valid & wr_ready);
      check("rd_while_empty", fifo_read & fifo_empty, 0);
      if (cmd_valid && cmd_ready) begin
        check("cmd_expected", exp_addr.size() != 0, 1);
        if (exp_addr.size() != 0) check("cmd_addr", cmd_addr, exp_addr.pop_front());
      end
      if (wr_valid && wr_ready) begin
        n_reads++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        check("data_expected", exp_data.size() != 0, 1);
        if (exp_data.size() != 0) check("wr_data", wr_data, exp_data.pop_front());
      end
      if (fifo_read) do_pop = 1'b1;
      if (busy) n_busy++;
      if (frame_done) begin
        n_fd++;
        check("fd_with_idle", busy, 0);
        check("fd_after_last_beat", prev_rd, 1);
      end
      prev_rd = fifo_read;
    end else begin
      check("rd_during_rst", fifo_read, 0);
    end
    @(posedge clk);
    #1;
    if (do_pop && fq.size() != 0) void'(fq.pop_front());
    do_pop = 1'b0;
    refresh();
  endtask

  task automatic wait_reads(input int target);
    for (int i = 0; i < 200 && n_reads < target; i++) cycle();
    check("reads_reached", n_reads, target);
  endtask

  task automatic burst(input int addr);
    exp_addr.push_back(addr);
    n_reads = 0;
    push(8);
    wait_reads(8);
    cycle();
    cycle();
    check("burst_idle", busy, 0);
    check("burst_drained", exp_data.size(), 0);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    n_reads = 0; n_busy = 0; n_fd = 0; first_rd = -1; last_rd = -1;
    hide = 1'b0; do_pop = 1'b0; prev_rd = 1'b0; next_word = '0;
    rst = 1'b1; frame_start = 1'b0; cmd_ready = 1'b0; wr_ready = 1'b0;
    refresh();
    repeat (3) cycle();

    // Reset state
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_fifo_read", fifo_read, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_cmd_addr", cmd_addr, 0);
    rst = 1'b0;

    // Seven words are not a burst
    push(7);
    repeat (5) cycle();
    check("no_cmd_at_7", cmd_valid, 0);
    check("idle_at_7", busy, 0);

    // Eighth word starts the first burst at address 0
    exp_addr.push_back(0);
    cmd_ready = 1'b1; wr_ready = 1'b1;
    n_reads = 0; n_busy = 0; first_rd = -1;
    push(1);
    cycle();
    check("cmd_latency", cmd_valid, 1);
    check("cmd_addr_first", cmd_addr, 0);
    repeat (11) cycle();
    check("t1_reads", n_reads, 8);
    check("t1_consecutive", last_rd - first_rd, 7);
    check("t1_busy_cycles", n_busy, 9);
    check("t1_drained", exp_data.size(), 0);

    // Command and data backpressure, burst at 8
    cmd_ready = 1'b0; wr_ready = 1'b0;
    exp_addr.push_back(8);
    n_reads = 0;
    push(8);
    cycle();
    for (int i = 0; i < 5; i++) begin
      check("cmd_hold_valid", cmd_valid, 1);
      check("cmd_hold_addr", cmd_addr, 8);
      cycle();
    end
    cmd_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      wr_ready = i[0];
      cycle();
    end
    wr_ready = 1'b1;
    cycle();
    cycle();
    check("t2_reads", n_reads, 8);
    check("t2_drained", exp_data.size(), 0);
    check("t2_idle", busy, 0);

    // FIFO runs dry after beat 3, burst at 16
    exp_addr.push_back(16);
    n_reads = 0;
    push(8);
    wait_reads(4);
    hide = 1'b1;
    refresh();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("stall_wr_valid", wr_valid, 0);
      check("stall_fifo_read", fifo_read, 0);
    end
    check("stall_beats_held", n_reads, 4);
    hide = 1'b0;
    refresh();
    wait_reads(8);
    cycle();
    cycle();
    check("t3_drained", exp_data.size(), 0);
    check("t3_idle", busy, 0);

    // Final burst of the frame at 24 wraps back to 0
    n_fd = 0;
    burst(24);
    check("wrap_frame_done", n_fd, 1);
    n_fd = 0;
    burst(0);
    check("after_wrap_no_fd", n_fd, 0);

    // frame_start during beat 2 of the burst at 16
    burst(8);
    exp_addr.push_back(16);
    n_reads = 0;
    push(8);
    wait_reads(2);
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    wait_reads(8);
    cycle();
    cycle();
    burst(0);
    check("restart_no_fd", n_fd, 0);

    // frame_start while idle
    frame_start = 1'b1;
    cycle();
    frame_start = 1'b0;
    cycle();
    burst(0);

    // Reset during beat 4 of the burst at 8
    exp_addr.push_back(8);
    n_reads = 0;
    push(8);
    wait_reads(4);
    rst = 1'b1;
    cycle();
    fq.delete();
    exp_data.delete();
    exp_addr.delete();
    refresh();
    check("mid_rst_cmd_valid", cmd_valid, 0);
    check("mid_rst_wr_valid", wr_valid, 0);
    check("mid_rst_fifo_read", fifo_read, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_frame_done", frame_done, 0);
    check("mid_rst_cmd_addr", cmd_addr, 0);
    rst = 1'b0;
    cycle();
    burst(0);
    check("post_rst_cmds", exp_addr.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_writer.md
# fifo_burst_writer

Single-clock drain stage on the read side of the camera-to-SDRAM asynchronous FIFO. Waits until the FIFO holds at least one full burst, issues a write command to the SDRAM controller, then streams exactly BURST_LEN words from the first-word-fall-through FIFO output to the controller. It generates frame-relative addresses and wraps them at the end of each frame, so the CNN input frame buffer is filled linearly.

## Interface
Parameters:
- DATA_WIDTH, 16: FIFO word / SDRAM data width.
- COUNT_WIDTH, 10: width of the FIFO read-side occupancy count.
- ADDR_WIDTH, 24: SDRAM word-address width.
- BURST_LEN, 8: words per burst, power of two, 2..2^(COUNT_WIDTH-1).
- FRAME_WORDS, 76800: words per frame, integer multiple of BURST_LEN.
- BASE_ADDR, 0: frame buffer start address, BURST_LEN-aligned.

Ports:
- clk, in, 1: single clock; same as the FIFO read clock.
- rst, in, 1: synchronous, active-high reset.
- fifo_empty, in, 1: FIFO empty flag (read domain).
- fifo_count, in, COUNT_WIDTH: FIFO read-side occupancy; may under-report, never over-reports.
- fifo_data, in, DATA_WIDTH: FIFO head word (first-word-fall-through).
- fifo_read, out, 1: pop request; combinational.
- frame_start, in, 1: one-cycle pulse; restarts addressing at BASE_ADDR.
- cmd_valid, out, 1: write command valid.
- cmd_ready, in, 1: controller accepts command.
- cmd_addr, out, ADDR_WIDTH: burst start address.
- wr_valid, out, 1: write data valid.
- wr_ready, in, 1: controller accepts data beat.
- wr_data, out, DATA_WIDTH: write data = fifo_data.
- busy, out, 1: high when state is not IDLE.
- frame_done, out, 1: one-cycle pulse after the last burst of a frame completes.

## Operation
- States: IDLE, CMD, DATA.
- IDLE:
  - Apply a pending or current frame_start: addr <= BASE_ADDR, clear the pending flag, stay IDLE that cycle.
  - Otherwise, if fifo_count >= BURST_LEN, go to CMD.
- CMD:
  - cmd_valid=1, cmd_addr=addr.
  - On cmd_valid&cmd_ready, clear beat counter and go to DATA.
- DATA:
  - wr_valid = !fifo_empty; wr_data = fifo_data; fifo_read = wr_valid & wr_ready.
  - Each accepted beat increments the beat counter (log2(BURST_LEN) bits).
  - On the accepted beat with count = BURST_LEN-1:
    - If addr+BURST_LEN == BASE_ADDR+FRAME_WORDS, set addr <= BASE_ADDR and register frame_done; otherwise addr <= addr+BURST_LEN.
    - Go to IDLE.
- FIFO empty mid-burst: wr_valid drops and the beat counter holds. No error and no timeout; the burst resumes when data appears.
- fifo_read is never asserted outside DATA or while fifo_empty=1.
- frame_start outside IDLE sets a pending flag. The in-flight burst completes at its original address, and the flag is applied in the next IDLE cycle. If the final burst also wraps, the address is BASE_ADDR either way.
- Arithmetic: addr is ADDR_WIDTH bits, modulo 2^ADDR_WIDTH. The end compare uses an ADDR_WIDTH+1-bit sum.

## Timing
- Reset values: state=IDLE, addr=BASE_ADDR, pending=0, beat=0, frame_done=0. All outputs are 0: cmd_valid, wr_valid, fifo_read, busy, frame_done. cmd_addr=BASE_ADDR.
- A reset asserted mid-burst aborts immediately. No further fifo_read is issued. Words already popped are lost; the FIFO is reset alongside the block.
- fifo_count >= BURST_LEN sampled in IDLE at edge N -> cmd_valid=1 in cycle N+1.
- cmd_valid and cmd_addr are held stable until cmd_ready.
- With wr_ready and !fifo_empty held high, beats occupy BURST_LEN consecutive cycles, one per cycle. The FIFO presents the next head word on the cycle after fifo_read.
- Best-case cadence: BURST_LEN+2 cycles per burst (IDLE, CMD, BURST_LEN×DATA).
- frame_done is high for exactly the one cycle after the final beat handshake, coincident with the return to IDLE.
- busy = (state != IDLE), registered with the state.

## Test plan
- Reset then fill: fifo_count=7 gives no cmd_valid. fifo_count=8 with cmd_ready=1 gives cmd_addr=0, then 8 beats of data 0x0000..0x0007 in 8 consecutive cycles, 8 fifo_read pulses, busy high for 9 cycles.
- Backpressure:
  - Hold cmd_ready=0 for 5 cycles: cmd_valid and cmd_addr are stable.
  - Toggle wr_ready 1/0 during DATA: fifo_read is asserted only on handshake cycles, and exactly 8 words are transferred in order.
- Underflow stall: fifo_empty=1 after beat 3 for 4 cycles gives wr_valid=0 and fifo_read=0. Beats 4..7 resume with correct data and no duplicates.
- Frame wrap with FRAME_WORDS=32, BURST_LEN=8:
  - Bursts start at addresses 0, 8, 16, 24.
  - frame_done pulses once, after the 4th burst.
  - The next burst starts at 0.
- frame_start mid-burst: pulse at beat 2 of the burst at address 16. That burst completes at 16, and the next burst starts at BASE_ADDR=0 with no frame_done.
- Reset mid-DATA: rst during beat 4 gives all outputs 0 the next cycle. After release, the first burst uses cmd_addr=BASE_ADDR.
